// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load lane extraction, sign/zero extension, write-back mux and misalignment flag.
// Optional stall/flush event counters are enabled with `define MEM_WB_PERF_CNT_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,  // 32 or 64
  parameter int REG_AW = 5,
  localparam int LANE_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [LANE_W-1:0] addr_lo_i,
  input  logic [1:0]        load_size_i,
  input  logic              load_unsigned_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  output logic              valid_o,
  output logic [REG_AW-1:0] wb_reg_o,
  output logic              reg_write_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] alu_data_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misalign_o
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam bit IS64 = (DATA_W == 64);
  localparam logic [LANE_W-1:0] HALF_MASK = ~LANE_W'(1);
  localparam logic [LANE_W-1:0] WORD_MASK = ~LANE_W'(3);

  logic [LANE_W-1:0] offset;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] fieldMask;
  logic [DATA_W-1:0] topBit;
  logic [DATA_W-1:0] fieldVal;
  logic [DATA_W-1:0] alignedData;
  logic              signBit;
  logic              sizeMis;
  logic              misalignIn;
  logic              regWriteIn;

  // The field mask doubles as the extension mask: bits above the field get the sign.
  // A full-width field leaves no bits above it, so it is never extended.
  always_comb begin
    offset    = '0;
    fieldMask = '0;
    sizeMis   = 1'b0;
    case (load_size_i)
      2'b00: begin
        offset    = addr_lo_i;
        fieldMask = DATA_W'(8'hFF);
      end
      2'b01: begin
        offset    = addr_lo_i & HALF_MASK;
        fieldMask = DATA_W'(16'hFFFF);
        sizeMis   = addr_lo_i[0];
      end
      2'b10: begin
        offset    = addr_lo_i & WORD_MASK;
        fieldMask = DATA_W'(32'hFFFF_FFFF);
        sizeMis   = |addr_lo_i[1:0];
      end
      default: begin
        if (IS64) begin
          offset    = '0;
          fieldMask = '1;
          sizeMis   = |addr_lo_i;
        end else begin
          offset    = addr_lo_i & WORD_MASK;
          fieldMask = DATA_W'(32'hFFFF_FFFF);
          sizeMis   = |addr_lo_i[1:0];
        end
      end
    endcase
    shifted     = mem_data_i >> {offset, 3'b000};
    fieldVal    = shifted & fieldMask;
    topBit      = fieldMask & ~(fieldMask >> 1);
    signBit     = |(shifted & topBit);
    alignedData = fieldVal | ((signBit & ~load_unsigned_i) ? ~fieldMask : '0);
  end

  assign misalignIn = mem_to_reg_i & valid_i & sizeMis;
  assign regWriteIn = valid_i & reg_write_i & (|wb_reg_i) & ~misalignIn;

  // Flush only kills the control bits; data registers keep stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      wb_reg_o     <= '0;
      reg_write_o  <= 1'b0;
      mem_data_o   <= '0;
      alu_data_o   <= '0;
      mem_to_reg_o <= 1'b0;
      misalign_o   <= 1'b0;
    end else if (flush_i) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      misalign_o  <= 1'b0;
    end else if (!stall_i) begin
      valid_o      <= valid_i;
      wb_reg_o     <= wb_reg_i;
      reg_write_o  <= regWriteIn;
      mem_data_o   <= alignedData;
      alu_data_o   <= alu_data_i;
      mem_to_reg_o <= mem_to_reg_i;
      misalign_o   <= misalignIn;
    end
  end

  assign wb_data_o = mem_to_reg_o ? mem_data_o : alu_data_o;

`ifdef MEM_WB_PERF_CNT_EN
  // Saturating event counters; a stall only counts while a live instruction is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_i && !flush_i && valid_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: one 32-bit and one 64-bit instance against a byte-level reference model.
// Counter checks are compiled in when MEM_WB_PERF_CNT_EN is defined.
module tb_mem_wb_stage;

  typedef struct {
    logic        valid;
    logic        rw;
    logic        mis;
    logic        m2r;
    logic [4:0]  rd;
    logic [63:0] mem;
    logic [63:0] alu;
    logic        known;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, vld = 1'b0;
  logic [63:0] memData = '0, aluData = '0;
  logic [2:0]  addrLo = '0;
  logic [1:0]  loadSize = '0;
  logic        loadUns = 1'b0, regWr = 1'b0, m2r = 1'b0;
  logic [4:0]  wbReg = '0;

  logic        v32, rw32, mr32, mis32, v64, rw64, mr64, mis64;
  logic [4:0]  rd32, rd64;
  logic [31:0] md32, ad32, wb32;
  logic [63:0] md64, ad64, wb64;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] sc32, fc32, sc64, fc64;
`endif

  int total = 0;
  int bad = 0;
  st_t m32, m64;
  int expStall = 0, expFlush = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(vld),
    .mem_data_i(memData[31:0]), .alu_data_i(aluData[31:0]), .addr_lo_i(addrLo[1:0]),
    .load_size_i(loadSize), .load_unsigned_i(loadUns), .wb_reg_i(wbReg),
    .reg_write_i(regWr), .mem_to_reg_i(m2r),
    .valid_o(v32), .wb_reg_o(rd32), .reg_write_o(rw32), .mem_data_o(md32),
    .alu_data_o(ad32), .mem_to_reg_o(mr32), .wb_data_o(wb32), .misalign_o(mis32)
`ifdef MEM_WB_PERF_CNT_EN
    , .stall_cnt_o(sc32), .flush_cnt_o(fc32)
`endif
  );

  mem_wb_stage #(.DATA_W(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(vld),
    .mem_data_i(memData), .alu_data_i(aluData), .addr_lo_i(addrLo),
    .load_size_i(loadSize), .load_unsigned_i(loadUns), .wb_reg_i(wbReg),
    .reg_write_i(regWr), .mem_to_reg_i(m2r),
    .valid_o(v64), .wb_reg_o(rd64), .reg_write_o(rw64), .mem_data_o(md64),
    .alu_data_o(ad64), .mem_to_reg_o(mr64), .wb_data_o(wb64), .misalign_o(mis64)
`ifdef MEM_WB_PERF_CNT_EN
    , .stall_cnt_o(sc64), .flush_cnt_o(fc64)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for a given datapath width.
  function automatic int accBytes(input int w, input logic [1:0] size);
    case (size)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return w / 8;
    endcase
  endfunction

  function automatic logic [63:0] refLoad(input int w, input logic [63:0] mem, input int addr,
                                          input logic [1:0] size, input logic uns);
    int n, off;
    logic [63:0] fld, lowMask, wMask;
    wMask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    n = accBytes(w, size);
    off = (addr / n) * n;
    fld = (mem & wMask) >> (off * 8);
    lowMask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (n * 8)) - 64'd1);
    fld = fld & lowMask;
    if (!uns && (n * 8 < w) && fld[n*8-1]) fld = fld | ~lowMask;
    return fld & wMask;
  endfunction

  function automatic st_t nextState(input int w, input st_t cur);
    st_t nx;
    int addr, n;
    logic mis;
    nx = cur;
    addr = (w == 64) ? int'(addrLo) : int'(addrLo[1:0]);
    n = accBytes(w, loadSize);
    mis = m2r && vld && ((addr % n) != 0);
    if (flush) begin
      nx.valid = 1'b0;
      nx.rw = 1'b0;
      nx.mis = 1'b0;
      nx.known = 1'b0;
    end else if (!stall) begin
      nx.valid = vld;
      nx.rw = vld && regWr && (wbReg != 5'd0) && !mis;
      nx.mis = mis;
      nx.m2r = m2r;
      nx.rd = wbReg;
      nx.mem = refLoad(w, memData, addr, loadSize, loadUns);
      nx.alu = (w == 64) ? aluData : {32'h0, aluData[31:0]};
      nx.known = 1'b1;
    end
    return nx;
  endfunction

  function automatic st_t zeroState();
    st_t z;
    z.valid = 1'b0; z.rw = 1'b0; z.mis = 1'b0; z.m2r = 1'b0;
    z.rd = '0; z.mem = '0; z.alu = '0; z.known = 1'b1;
    return z;
  endfunction

  task automatic cmpAll();
    chk("d32.valid", 64'(v32), 64'(m32.valid));
    chk("d32.rw", 64'(rw32), 64'(m32.rw));
    chk("d32.mis", 64'(mis32), 64'(m32.mis));
    chk("d64.valid", 64'(v64), 64'(m64.valid));
    chk("d64.rw", 64'(rw64), 64'(m64.rw));
    chk("d64.mis", 64'(mis64), 64'(m64.mis));
    if (m32.known) begin
      chk("d32.rd", 64'(rd32), 64'(m32.rd));
      chk("d32.mem", 64'(md32), m32.mem);
      chk("d32.alu", 64'(ad32), m32.alu);
      chk("d32.m2r", 64'(mr32), 64'(m32.m2r));
      chk("d32.wb", 64'(wb32), m32.m2r ? m32.mem : m32.alu);
    end
    if (m64.known) begin
      chk("d64.rd", 64'(rd64), 64'(m64.rd));
      chk("d64.mem", md64, m64.mem);
      chk("d64.alu", ad64, m64.alu);
      chk("d64.m2r", 64'(mr64), 64'(m64.m2r));
      chk("d64.wb", wb64, m64.m2r ? m64.mem : m64.alu);
    end
`ifdef MEM_WB_PERF_CNT_EN
    chk("d32.stallcnt", 64'(sc32), 64'(expStall));
    chk("d32.flushcnt", 64'(fc32), 64'(expFlush));
    chk("d64.stallcnt", 64'(sc64), 64'(expStall));
    chk("d64.flushcnt", 64'(fc64), 64'(expFlush));
`endif
  endtask

  // One clock: predict from the current inputs, take the edge, then compare.
  task automatic step();
    st_t n32, n64;
    n32 = nextState(32, m32);
    n64 = nextState(64, m64);
    if (stall && !flush && m64.valid) expStall++;
    if (flush) expFlush++;
    @(posedge clk);
    #1;
    m32 = n32;
    m64 = n64;
    cmpAll();
  endtask

  task automatic setIn(input logic v, input logic [63:0] md, input logic [63:0] ad,
                       input logic [2:0] a, input logic [1:0] sz, input logic u,
                       input logic [4:0] r, input logic w, input logic mr);
    vld = v; memData = md; aluData = ad; addrLo = a; loadSize = sz;
    loadUns = u; wbReg = r; regWr = w; m2r = mr;
  endtask

  task automatic checkZero(input string tag);
    chk({tag, ".valid"}, 64'(v32 | v64), 64'd0);
    chk({tag, ".rw"}, 64'(rw32 | rw64), 64'd0);
    chk({tag, ".mis"}, 64'(mis32 | mis64), 64'd0);
    chk({tag, ".rd"}, 64'(rd32 | rd64), 64'd0);
    chk({tag, ".data"}, 64'(md32 | ad32 | wb32) | md64 | ad64 | wb64, 64'd0);
    chk({tag, ".m2r"}, 64'(mr32 | mr64), 64'd0);
  endtask

  initial begin
    m32 = zeroState();
    m64 = zeroState();
    #1;
    checkZero("reset0");
    #3 rst_n = 1'b1;
    step();

    // Signed / unsigned byte at offset 2
    setIn(1, 64'h0000_0000_80FF_7F01, 64'h0, 3'd2, 2'b00, 0, 5'd5, 1, 1);
    step();
    chk("byte_s.mem", 64'(md32), 64'hFFFF_FFFF);
    chk("byte_s.wb", 64'(wb32), 64'hFFFF_FFFF);
    chk("byte_s.rw", 64'(rw32), 64'd1);
    loadUns = 1;
    step();
    chk("byte_u.mem", 64'(md32), 64'h0000_00FF);

    // Halfword, then ALU write-back select
    setIn(1, 64'h0000_0000_80FF_7F01, 64'h0, 3'd2, 2'b01, 0, 5'd5, 1, 1);
    step();
    chk("half_s.mem", 64'(md32), 64'hFFFF_80FF);
    setIn(1, 64'h0000_0000_80FF_7F01, 64'h1234, 3'd2, 2'b01, 0, 5'd5, 1, 0);
    step();
    chk("alu_sel.wb", 64'(wb32), 64'h1234);

    // Misaligned half and r0 suppression
    setIn(1, 64'h0000_0000_80FF_7F01, 64'h0, 3'd1, 2'b01, 0, 5'd5, 1, 1);
    step();
    chk("mis_half.mis", 64'(mis32), 64'd1);
    chk("mis_half.rw", 64'(rw32), 64'd0);
    setIn(1, 64'h0000_0000_80FF_7F01, 64'h77, 3'd0, 2'b10, 0, 5'd0, 1, 0);
    step();
    chk("r0.rw", 64'(rw32), 64'd0);

    // Load A, stall three cycles with B, then stall+flush
    setIn(1, 64'h1111_2222_3333_4444, 64'hA, 3'd0, 2'b10, 0, 5'd7, 1, 0);
    step();
    setIn(1, 64'h5555_6666_7777_8888, 64'hB, 3'd0, 2'b10, 1, 5'd9, 1, 1);
    stall = 1;
    repeat (3) step();
    chk("stall.alu", 64'(ad32), 64'hA);
    chk("stall.rd", 64'(rd32), 64'd7);
    flush = 1;
    step();
    chk("flush.valid", 64'(v32), 64'd0);
    chk("flush.rw", 64'(rw32), 64'd0);
`ifdef MEM_WB_PERF_CNT_EN
    chk("perf.stall", 64'(sc32), 64'd3);
    chk("perf.flush", 64'(fc32), 64'd1);
`endif
    stall = 0;
    flush = 0;

    // Full-width 64-bit load, aligned then misaligned
    setIn(1, 64'h8000_0000_0000_0001, 64'h0, 3'd0, 2'b11, 0, 5'd3, 1, 1);
    step();
    chk("full64.mem", md64, 64'h8000_0000_0000_0001);
    addrLo = 3'd4;
    step();
    chk("full64.mis", 64'(mis64), 64'd1);
    chk("full64.rw", 64'(rw64), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      setIn(($urandom_range(0, 9) < 8), {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) == 0);
      step();
    end

    // Asynchronous reset mid-cycle while stalled with live inputs
    setIn(1, 64'hDEAD_BEEF_CAFE_F00D, 64'h55, 3'd0, 2'b10, 0, 5'd4, 1, 1);
    stall = 0;
    flush = 0;
    step();
    stall = 1;
    #3 rst_n = 1'b0;
    #1;
    checkZero("reset_mid");
    m32 = zeroState();
    m64 = zeroState();
    expStall = 0;
    expFlush = 0;
`ifdef MEM_WB_PERF_CNT_EN
    chk("reset_mid.cnt", 64'(sc32 | fc32 | sc64 | fc64), 64'd0);
`endif
    #2 rst_n = 1'b1;
    stall = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
